// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file definitions plus the scoreboard counter and address types.
package reg_scoreboard_pkg;

  localparam int XLEN       = 32;
  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 2;
  localparam int IFL_W      = 4;
  localparam int STALL_W    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      sb_cnt_t;
  typedef logic [IFL_W-1:0]      ifl_cnt_t;

  localparam reg_addr_t       X0        = '0;
  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  localparam sb_cnt_t  CNT_MAX = '1;
  localparam ifl_cnt_t IFL_MAX = '1;

endpackage

// File: rtl/reg_sb_counter.sv
// Pending-write counter for one architectural register.
module reg_sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  input  logic    dec,
  output sb_cnt_t cnt,
  output logic    zero
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && !dec)
      cnt <= cnt + 1'b1;
    else if (dec && !inc)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue scheduler: gates ID issue on RAW and write-count hazards,
// releases tracked writes from WB.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid_i,
  input  logic               rs1_en_i,
  input  reg_addr_t          rs1_addr_i,
  input  logic               rs2_en_i,
  input  reg_addr_t          rs2_addr_i,
  input  logic               rd_en_i,
  input  reg_addr_t          rd_addr_i,
  output logic               issue_ready_o,
  input  logic               rel_valid_i,
  input  reg_addr_t          rel_addr_i,
  output logic [REG_NUM-1:0] busy_o,
  output ifl_cnt_t           inflight_o,
  output logic [STALL_W-1:0] stall_cnt_o,
  output logic               err_o
);

  logic [REG_NUM-1:0][CNT_W-1:0] cnt;
  logic [REG_NUM-1:0][CNT_W-1:0] eff;
  logic [REG_NUM-1:0]            nz;
  logic [REG_NUM-1:0]            zero;
  logic [REG_NUM-1:0]            rel_hit;
  logic [REG_NUM-1:0]            inc;

  logic     any_rel;
  logic     rel_miss;
  logic     trk;
  logic     raw1;
  logic     raw2;
  logic     waw_sat;
  logic     ifl_sat;
  logic     fire;
  logic     wr;
  ifl_cnt_t ifl_net;

  assign cnt[0]  = '0;
  assign zero[0] = 1'b1;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
    reg_sb_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[r]),
      .dec  (rel_hit[r]),
      .cnt  (cnt[r]),
      .zero (zero[r])
    );
  end

  assign nz = ~zero;

  always_comb begin
    rel_hit = '0;
    inc     = '0;
    eff     = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      rel_hit[r] = rel_valid_i && nz[r] &&
                   (rel_addr_i == REG_ADDR_W'(r));
      inc[r]     = wr && (rd_addr_i == REG_ADDR_W'(r));
      eff[r]     = cnt[r] - CNT_W'(rel_hit[r]);
    end
  end

  assign any_rel  = |rel_hit;
  assign rel_miss = rel_valid_i && (rel_addr_i != X0) &&
                    !nz[rel_addr_i];

  // A same-cycle release counts as retired: the file forwards WB data.
  assign trk  = rd_en_i && (rd_addr_i != X0);
  assign raw1 = rs1_en_i && (rs1_addr_i != X0) &&
                (eff[rs1_addr_i] != '0);
  assign raw2 = rs2_en_i && (rs2_addr_i != X0) &&
                (eff[rs2_addr_i] != '0);

  assign waw_sat = trk && (eff[rd_addr_i] == CNT_MAX);
  assign ifl_net = inflight_o - IFL_W'(any_rel);
  assign ifl_sat = trk && (ifl_net == IFL_MAX);

  assign issue_ready_o = !rst && !raw1 && !raw2 &&
                         !waw_sat && !ifl_sat;

  assign fire = issue_valid_i && issue_ready_o;
  assign wr   = fire && trk;

  assign busy_o = nz;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_o  <= '0;
      stall_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (wr && !any_rel)
        inflight_o <= inflight_o + 1'b1;
      else if (any_rel && !wr)
        inflight_o <= inflight_o - 1'b1;
      if (issue_valid_i && !issue_ready_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (rel_miss)
        err_o <= 1'b1;
    end
  end

endmodule
